act_neuron_seq: RTL and testbench

//  Next-generation neuron: NUM inputs plus bias, selectable activation (identity / hard-sigmoid /

---
 rtl/act_neuron_seq.sv | 179 +++++++++++++++++
 tb/tb_act_neuron_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_neuron_seq.sv
// act_neuron_seq
//   Sequential fixed-point neuron: NUM inputs plus a bias, one shared
//   multiplier doing one MAC per cycle, then a selectable activation
//   (identity / hard-sigmoid / hard-tanh). Weights and bias live in an
//   internal register file with a write port (IDLE only) and an always-open
//   combinational read port for the backprop path.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready   input vector handshake; o_ready high only in IDLE
//   i_k, i_mode       input vector (element j at [j*WIDTH +: WIDTH]), mode
//   o_valid/i_ready   result handshake; outputs held until taken
//   o_a, o_da, o_sum  activation, its derivative, saturated pre-activation
//   wr, wr_addr,      weight write (addr NUM = bias); o_wr_err pulses one
//   wr_data, o_wr_err cycle when a write is dropped
//   rd_addr,          combinational read of weight memory, 0 out of range
//   o_rd_data
module act_neuron_seq #(
  parameter int NUM   = 8,
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int AW    = $clog2(NUM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NUM*WIDTH-1:0] i_k,
  input  logic [1:0]           i_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_a,
  output logic [WIDTH-1:0]     o_da,
  output logic [WIDTH-1:0]     o_sum,
  input  logic                 wr,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 o_wr_err,
  input  logic [AW-1:0]        rd_addr,
  output logic [WIDTH-1:0]     o_rd_data
);

  localparam int ACCW = 2*WIDTH + AW;

  localparam logic [AW-1:0] LAST_W = AW'(NUM - 1);
  localparam logic [AW-1:0] BIAS_A = AW'(NUM);

  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) <<< FRAC;
  localparam logic signed [WIDTH-1:0] HALF    = ONE >>> 1;
  localparam logic signed [WIDTH-1:0] QUART   = ONE >>> 2;
  localparam logic signed [WIDTH-1:0] TWO     = ONE <<< 1;
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
  localparam logic signed [WIDTH-1:0] NEG_TWO = -TWO;
  localparam logic signed [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] mem [NUM+1];
  logic signed [WIDTH-1:0] k_r [NUM];
  logic [1:0]              mode_r;
  logic signed [ACCW-1:0]  acc;
  logic [AW-1:0]           idx;

  logic                     wr_ok;
  logic signed [WIDTH-1:0]  bias_src;
  logic signed [ACCW-1:0]   bias_acc;
  logic signed [2*WIDTH-1:0] k_ext, w_ext, prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [ACCW-1:0]   acc_sh;
  logic [ACCW-WIDTH:0]      acc_hi;
  logic signed [WIDTH-1:0]  s_sat;
  logic signed [WIDTH-1:0]  hs;
  logic signed [WIDTH-1:0]  a_next, da_next;

  assign o_ready = (state == S_IDLE);
  assign wr_ok   = wr && (state == S_IDLE) && (wr_addr <= BIAS_A);

  assign o_rd_data = (rd_addr <= BIAS_A) ? mem[rd_addr] : '0;

  // A bias write landing on the accept edge must already be seen by the
  // accumulator seed, so forward it around the register file.
  assign bias_src = (wr_ok && wr_addr == BIAS_A) ? wr_data : mem[NUM];
  assign bias_acc = {{(ACCW-WIDTH){bias_src[WIDTH-1]}}, bias_src} <<< FRAC;

  // Sign-extend to 2*WIDTH first; the low 2*WIDTH bits of that product are
  // the exact signed product.
  assign k_ext    = {{WIDTH{k_r[idx][WIDTH-1]}}, k_r[idx]};
  assign w_ext    = {{WIDTH{mem[idx][WIDTH-1]}}, mem[idx]};
  assign prod     = k_ext * w_ext;
  assign prod_ext = {{AW{prod[2*WIDTH-1]}}, prod};

  // Saturate: in range iff every bit from WIDTH-1 upward matches the sign.
  assign acc_sh = acc >>> FRAC;
  assign acc_hi = acc_sh[ACCW-1:WIDTH-1];

  always_comb begin
    if ((&acc_hi) || (~|acc_hi)) s_sat = acc_sh[WIDTH-1:0];
    else if (acc_sh[ACCW-1])     s_sat = SMIN;
    else                         s_sat = SMAX;
  end

  always_comb begin
    a_next  = s_sat;
    da_next = ONE;
    hs      = (s_sat >>> 2) + HALF;
    case (mode_r)
      2'd1: begin
        if (hs[WIDTH-1])  a_next = '0;
        else if (hs > ONE) a_next = ONE;
        else               a_next = hs;
        da_next = (s_sat > NEG_TWO && s_sat < TWO) ? QUART : '0;
      end
      2'd2: begin
        if (s_sat > ONE)          a_next = ONE;
        else if (s_sat < NEG_ONE) a_next = NEG_ONE;
        else                      a_next = s_sat;
        da_next = (s_sat > NEG_ONE && s_sat < ONE) ? ONE : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      idx     <= '0;
      mode_r  <= '0;
      for (int unsigned j = 0; j < NUM; j++) k_r[j] <= '0;
      o_valid <= 1'b0;
      o_a     <= '0;
      o_da    <= '0;
      o_sum   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            for (int unsigned j = 0; j < NUM; j++) k_r[j] <= i_k[j*WIDTH +: WIDTH];
            mode_r <= i_mode;
            acc    <= bias_acc;
            idx    <= '0;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (idx == LAST_W) state <= S_ACT;
          else               idx   <= idx + 1'b1;
        end
        S_ACT: begin
          o_sum   <= s_sat;
          o_a     <= a_next;
          o_da    <= da_next;
          o_valid <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j <= NUM; j++) mem[j] <= '0;
      o_wr_err <= 1'b0;
    end else begin
      o_wr_err <= wr && !wr_ok;
      if (wr_ok) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_act_neuron_seq.sv
module tb_act_neuron_seq;
  localparam int NUM = 4, WIDTH = 32, FRAC = 16, AW = 3;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk = 1'b0, rst = 1'b0;
  logic i_valid = 1'b0, i_ready = 1'b1, wr = 1'b0;
  logic [1:0] i_mode = '0;
  logic [NUM*WIDTH-1:0] i_k = '0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic o_ready, o_valid, o_wr_err;
  logic [WIDTH-1:0] o_a, o_da, o_sum, o_rd_data;

  act_neuron_seq #(.NUM(NUM), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_k(i_k),
    .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready), .o_a(o_a),
    .o_da(o_da), .o_sum(o_sum), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .o_wr_err(o_wr_err), .rd_addr(rd_addr), .o_rd_data(o_rd_data));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] sum, a, da; int acc_cyc; } exp_t;
  exp_t q[$];
  logic [31:0] wm [5];
  int cyc = 0;
  int unsigned n_chk = 0, n_pass = 0;
  bit prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: exact wide arithmetic, floor shift, clamp, then piecewise activation.
  function automatic exp_t model(input logic [31:0] kv [4], input logic [1:0] mode);
    exp_t e;
    logic signed [127:0] acc, p;
    longint s, a, da;
    acc = $signed(wm[4]);
    acc = acc * 65536;
    for (int j = 0; j < 4; j++) begin
      p = $signed(kv[j]);
      p = p * $signed(wm[j]);
      acc = acc + p;
    end
    acc = acc >>> FRAC;
    if (acc > 128'sh7FFF_FFFF)        s = 64'sh7FFF_FFFF;
    else if (acc < -128'sh8000_0000)  s = -64'sh8000_0000;
    else                              s = longint'(acc);
    case (mode)
      2'd1: begin
        a = (s >>> 2) + 32768;
        if (a < 0) a = 0;
        if (a > 65536) a = 65536;
        da = (s > -131072 && s < 131072) ? 16384 : 0;
      end
      2'd2: begin
        a = (s > 65536) ? 65536 : (s < -65536) ? -65536 : s;
        da = (s > -65536 && s < 65536) ? 65536 : 0;
      end
      default: begin a = s; da = 65536; end
    endcase
    e.sum = s[31:0]; e.a = a[31:0]; e.da = da[31:0]; e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: latency on the rising edge of o_valid, values every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!rst) prev_v = 1'b0;
    else begin
      if (o_valid) begin
        if (q.size() == 0) begin
          if (!prev_v || i_ready) check("unexpected_valid", {31'd0, o_valid}, 32'd0);
        end else begin
          if (!prev_v) check("latency", 32'(cyc - q[0].acc_cyc), 32'(NUM + 1));
          check("o_sum", o_sum, q[0].sum);
          check("o_a", o_a, q[0].a);
          check("o_da", o_da, q[0].da);
          if (i_ready) void'(q.pop_front());
        end
      end
      prev_v = o_valid;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("ready_timeout", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic start_vec(input logic [31:0] kv [4], input logic [1:0] mode, input bit push,
                           input bit do_wr, input logic [2:0] wa, input logic [31:0] wd);
    exp_t e;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    #1;
    i_k = {kv[3], kv[2], kv[1], kv[0]};
    i_mode = mode;
    i_valid = 1'b1;
    if (do_wr) begin
      wr = 1'b1; wr_addr = wa; wr_data = wd;
      wm[wa] = wd;
    end
    if (push) begin
      e = model(kv, mode);
      e.acc_cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wr = 1'b0;
    if (do_wr) begin
      @(negedge clk);
      check("wr_err_same_edge", {31'd0, o_wr_err}, 32'd0);
    end
  endtask

  task automatic run(input logic [31:0] kv [4], input logic [1:0] mode);
    start_vec(kv, mode, 1'b1, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input bit exp_err);
    @(negedge clk);
    #1;
    wr = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    check("wr_err", {31'd0, o_wr_err}, {31'd0, exp_err});
    if (!exp_err) wm[a] = d;
    @(negedge clk);
    check("wr_err_pulse", {31'd0, o_wr_err}, 32'd0);
  endtask

  task automatic chk_read(input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check("rd_data", o_rd_data, exp);
  endtask

  function automatic logic [31:0] rnd_small();
    return 32'($urandom_range(0, 32'h80000)) - 32'h40000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] kv [4];
    logic [31:0] old1;
    bit ok;
    for (int j = 0; j < 5; j++) wm[j] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_ready", {31'd0, o_ready}, 32'd1);
    check("rst_o_wr_err", {31'd0, o_wr_err}, 32'd0);
    check("rst_o_a", o_a, 32'd0);
    check("rst_o_da", o_da, 32'd0);
    check("rst_o_sum", o_sum, 32'd0);
    for (int j = 0; j < 5; j++) chk_read(3'(j), 32'd0);
    #1 rst = 1'b1;

    // Directed: w={1.0,2.0,-1.0,0.5}, bias=0.25
    do_write(3'd0, 32'h0001_0000, 1'b0);
    do_write(3'd1, 32'h0002_0000, 1'b0);
    do_write(3'd2, 32'hFFFF_0000, 1'b0);
    do_write(3'd3, 32'h0000_8000, 1'b0);
    do_write(3'd4, 32'h0000_4000, 1'b0);
    for (int j = 0; j < 5; j++) chk_read(3'(j), wm[j]);
    for (int j = 0; j < 4; j++) kv[j] = ONE;
    run(kv, 2'd0);
    for (int j = 0; j < 4; j++) kv[j] = 32'h0000_8000;
    run(kv, 2'd1);
    run(kv, 2'd2);
    run(kv, 2'd3);
    drain();

    // Randomized vectors, weights refreshed periodically
    for (int it = 0; it < 30; it++) begin
      if (it % 6 == 0) begin
        drain();
        for (int j = 0; j < 5; j++) do_write(3'(j), rnd_small(), 1'b0);
      end
      for (int j = 0; j < 4; j++) kv[j] = (it % 7 == 3) ? $urandom : rnd_small();
      run(kv, 2'($urandom_range(0, 3)));
    end
    drain();

    // Positive and negative saturation
    for (int j = 0; j < 4; j++) do_write(3'(j), 32'h7FFF_0000, 1'b0);
    do_write(3'd4, 32'd0, 1'b0);
    for (int j = 0; j < 4; j++) kv[j] = 32'h7FFF_0000;
    run(kv, 2'd0);
    run(kv, 2'd2);
    for (int j = 0; j < 4; j++) kv[j] = 32'h8001_0000;
    run(kv, 2'd0);
    run(kv, 2'd1);
    drain();

    // Hold in DONE with i_ready low; i_valid must be ignored
    do_write(3'd0, 32'h0001_0000, 1'b0);
    do_write(3'd1, 32'h0002_0000, 1'b0);
    do_write(3'd2, 32'hFFFF_0000, 1'b0);
    do_write(3'd3, 32'h0000_8000, 1'b0);
    do_write(3'd4, 32'h0000_4000, 1'b0);
    @(posedge clk);
    #1 i_ready = 1'b0;
    for (int j = 0; j < 4; j++) kv[j] = ONE;
    run(kv, 2'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_valid) begin ok = 1'b1; break; end
    end
    check("hold_valid_seen", {31'd0, ok}, 32'd1);
    #1;
    i_k = {4{32'h0003_0000}};
    i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_o_ready", {31'd0, o_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_o_ready", {31'd0, o_ready}, 32'd1);
    check("release_o_valid", {31'd0, o_valid}, 32'd0);
    drain();

    // Write during MAC dropped, read still returns the old value
    for (int j = 0; j < 4; j++) kv[j] = 32'h0000_8000;
    old1 = wm[1];
    run(kv, 2'd0);
    do_write(3'd1, 32'h1234_5678, 1'b1);
    chk_read(3'd1, old1);
    drain();
    chk_read(3'd1, old1);

    // Out-of-range addresses
    do_write(3'd5, 32'hDEAD_BEEF, 1'b1);
    do_write(3'd7, 32'hDEAD_BEEF, 1'b1);
    chk_read(3'd5, 32'd0);
    chk_read(3'd6, 32'd0);
    chk_read(3'd7, 32'd0);
    chk_read(3'd4, wm[4]);

    // Write and accept on the same edge: bias, then first weight
    for (int j = 0; j < 4; j++) kv[j] = ONE;
    start_vec(kv, 2'd0, 1'b1, 1'b1, 3'd4, 32'h0003_0000);
    drain();
    start_vec(kv, 2'd2, 1'b1, 1'b1, 3'd0, 32'hFFFC_0000);
    drain();

    // Reset during MAC aborts; weights clear; fresh run sums to zero
    start_vec(kv, 2'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 5; j++) wm[j] = '0;
    repeat (2) @(negedge clk);
    check("midrst_o_valid", {31'd0, o_valid}, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("postrst_o_ready", {31'd0, o_ready}, 32'd1);
    check("postrst_o_valid", {31'd0, o_valid}, 32'd0);
    for (int j = 0; j < 5; j++) chk_read(3'(j), 32'd0);
    repeat (10) @(negedge clk);
    for (int j = 0; j < 4; j++) kv[j] = rnd_small();
    run(kv, 2'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
